fb_scanout: RTL and testbench
=============================

# fb_scanout

Single-clock framebuffer scan-out engine for the HDMI path. It turns the video timing generator's signed pixel coordinates into framebuffer read requests and optionally upscales the image by an integer power of two. It maps each returned shade index through a 24-bit palette and delivers RGB with sync and data-enable delayed by the same number of cycles. It sits between the timing generator and the TMDS encoder and drives the read port of the dual-port framebuffer RAM.

## Interface
- `H_RES`, 640: active width in output pixels.
- `V_RES`, 480: active height in output pixels.
- `SCALE_LOG2`, 0: upscale factor is 2**SCALE_LOG2 (0..3). Framebuffer size is (H_RES>>SCALE_LOG2) x (V_RES>>SCALE_LOG2).
- `PIX_W`, 6: shade index width.
- `NUM_SHADES`, 24: number of ramp entries, 2..2**PIX_W.
- `ADDR_W`, 20: framebuffer address width.
- `RAM_LAT`, 1: framebuffer read latency in cycles, 1..2.
- `BORDER_RGB`, 24'h000000: colour output for out-of-bounds coordinates.
- `clk`  in  1  pixel clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `i_x`, `i_y`  in  16 each, signed  current timing coordinates.
- `i_hsync`, `i_vsync`, `i_de`  in  1 each  timing signals aligned with `i_x`/`i_y`.
- `fb_rd_en`  out  1  read strobe.
- `fb_addr`  out  ADDR_W  read address.
- `fb_data`  in  PIX_W  read data, valid RAM_LAT cycles after `fb_rd_en`.
- `o_red`, `o_green`, `o_blue`  out  8 each  pixel colour.
- `o_hsync`, `o_vsync`, `o_de`  out  1 each  delayed timing signals.
- `pal_we`  in  1  palette write strobe (macro only).
- `pal_addr`  in  PIX_W  palette write index (macro only).
- `pal_data`  in  24  {R,G,B} palette write data (macro only).

## Operation
- **In-bounds test.** A coordinate is in bounds when 0<=i_x<H_RES and 0<=i_y<V_RES.
- **Read request.** In bounds: `fb_rd_en`=1 and `fb_addr` = row_base + (i_x>>SCALE_LOG2). Otherwise `fb_rd_en`=0 and `fb_addr` holds its previous value.
- **row_base is computed incrementally; no multiplier.**
  - i_y<=0: row_base <= 0.
  - i_y increments and (i_y>>SCALE_LOG2) increments: row_base += H_RES>>SCALE_LOG2.
  - All other cases: hold.
  - A jump in i_y of more than 1 is not a legal input. After such a jump, row_base is correct from the next frame (i_y returning to 0).
- **Pipeline.**
  - Stage A registers address, in-bounds flag and sync bits.
  - RAM_LAT delay stages carry the in-bounds flag and sync bits alongside the RAM read.
  - Stage P registers the palette lookup: RGB = palette[fb_data] if in bounds, else BORDER_RGB.
- **Default palette (grey ramp).**
  - Entry i < NUM_SHADES: grey level g = floor(i*255/(NUM_SHADES-1)), R=G=B=g.
  - Entries >= NUM_SHADES: 24'hFFFFFF.
- **Width rule.** All address arithmetic is ADDR_W bits and unsigned after the bounds check. A negative coordinate never reaches the adder.

## Timing
- Latency from `i_*` to `o_*` is RAM_LAT+2 cycles, for RGB and sync/de alike, fixed.
- `fb_addr`/`fb_rd_en` are registered: one cycle after `i_x`/`i_y`.
- Throughput: one pixel per cycle, no stalls.
- **Reset values.**
  - `o_red`/`o_green`/`o_blue` = 0; `o_hsync`/`o_vsync`/`o_de` = 0.
  - `fb_rd_en` = 0; `fb_addr` = 0.
  - row_base = 0; all pipeline in-bounds flags cleared.
- **Reset mid-frame.** Outputs stay at their reset values for RAM_LAT+2 cycles after `rst` deasserts. After that they follow the input delayed by the latency. row_base is wrong until i_y next reaches 0.
- **Palette contents and reset.** Palette contents are not affected by `rst`.

## Configuration
- `SCANOUT_PALETTE_WR_EN` defined:
  - The palette is a register array initialised to the grey ramp and writable via `pal_we`/`pal_addr`/`pal_data`.
  - A write is visible to lookups in stage P starting the cycle after `pal_we`.
  - A lookup in the same cycle as a write to the same entry returns the old value.
- `SCANOUT_PALETTE_WR_EN` undefined:
  - The palette is the constant grey ramp; the `pal_*` ports do not exist.

## Test plan
- **Default mapping.** Defaults, raster sweep, fb_data = index 1 at (0,0) -> RGB 0x0b0b0b on `o_*` 3 cycles later; index 23 -> 0xffffff; index 40 -> 0xffffff.
- **Out of bounds.** i_x=-1 and i_x=640 (i_y=10) -> `fb_rd_en`=0, RGB=BORDER_RGB; syncs still delayed 3 cycles.
- **Upscaling.** SCALE_LOG2=1:
  - i_y 0..3 yields row_base 0,0,320,320.
  - (i_x,i_y)=(5,3) -> `fb_addr`=322.
  - Full frame covers addresses 0..76799 exactly, each read 4 times.
- **Read latency.** RAM_LAT=2 -> RGB/sync latency 4; a one-pixel marker at (100,50) appears at the output exactly 4 cycles after it is presented on the input.
- **Reset mid-frame.** `rst` pulse at (320,240) -> all outputs 0 for 3 cycles after release; next frame addresses are correct from (0,0).
- **Palette write (macro).** Write entry 5 = 0xff0000 while index 5 streams -> old colour in the write cycle, 0xff0000 from the next cycle; `rst` keeps 0xff0000.

Source files
------------

// File: rtl/fb_scanout_if.sv
// Framebuffer read port: fb_scanout drives the request (master), the
// dual-port RAM returns the shade index (slave).
interface fb_scanout_if #(
  parameter int ADDR_W = 20,
  parameter int PIX_W  = 6
);
  logic              fb_rd_en;
  logic [ADDR_W-1:0] fb_addr;
  logic [PIX_W-1:0]  fb_data;

  modport master (output fb_rd_en, output fb_addr, input fb_data);
  modport slave  (input fb_rd_en, input fb_addr, output fb_data);
endinterface

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: timing coordinates -> RAM reads -> palette -> RGB.
// Define SCANOUT_PALETTE_WR_EN for a writable palette (pal_* ports).
module fb_scanout #(
  parameter int          H_RES      = 640,
  parameter int          V_RES      = 480,
  parameter int          SCALE_LOG2 = 0,
  parameter int          PIX_W      = 6,
  parameter int          NUM_SHADES = 24,
  parameter int          ADDR_W     = 20,
  parameter int          RAM_LAT    = 1,
  parameter logic [23:0] BORDER_RGB = 24'h000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] i_x,
  input  logic signed [15:0] i_y,
  input  logic               i_hsync,
  input  logic               i_vsync,
  input  logic               i_de,
  fb_scanout_if.master       fb,
`ifdef SCANOUT_PALETTE_WR_EN
  input  logic               pal_we,
  input  logic [PIX_W-1:0]   pal_addr,
  input  logic [23:0]        pal_data,
`endif
  output logic [7:0]         o_red,
  output logic [7:0]         o_green,
  output logic [7:0]         o_blue,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_de
);

  localparam int                 PAL_N    = 2 ** PIX_W;
  localparam logic signed [15:0] H_LIM    = 16'(H_RES);
  localparam logic signed [15:0] V_LIM    = 16'(V_RES);
  localparam logic [ADDR_W-1:0]  ROW_STEP = ADDR_W'(H_RES >> SCALE_LOG2);

  function automatic logic [23:0] ramp_entry(input int unsigned i);
    logic [7:0] g;
    if (i < unsigned'(NUM_SHADES)) begin
      g = 8'((i * 255) / unsigned'(NUM_SHADES - 1));
      return {g, g, g};
    end
    return 24'hFFFFFF;
  endfunction

  logic signed [15:0] y_prev_q;
  logic [ADDR_W-1:0]  row_base_q, row_base_d;
  logic [ADDR_W-1:0]  addr_q, addr_d, x_off;
  logic               in_bounds;
  logic               rd_en_q, vld_a_q, ib_a_q;
  logic [2:0]         sync_a_q;
  logic [RAM_LAT-1:0] vld_dl_q, ib_dl_q;
  logic [2:0]         sync_dl_q [RAM_LAT];
  logic [23:0]        pal_rd, rgb_d, rgb_q;
  logic [2:0]         sync_p_q;

  // row_base tracks i_y by stepping one framebuffer row whenever the scaled
  // line index advances, so the address needs only an adder.
  always_comb begin
    in_bounds = (i_x >= 16'sd0) && (i_x < H_LIM) && (i_y >= 16'sd0) && (i_y < V_LIM);
    row_base_d = row_base_q;
    if (i_y <= 16'sd0) begin
      row_base_d = '0;
    end else if ((i_y == y_prev_q + 16'sd1) &&
                 ((i_y >>> SCALE_LOG2) != (y_prev_q >>> SCALE_LOG2))) begin
      row_base_d = row_base_q + ROW_STEP;
    end
    x_off  = in_bounds ? ADDR_W'($unsigned(i_x) >> SCALE_LOG2) : '0;
    addr_d = in_bounds ? row_base_d + x_off : addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_prev_q   <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      vld_a_q    <= 1'b0;
      ib_a_q     <= 1'b0;
      sync_a_q   <= '0;
    end else begin
      y_prev_q   <= i_y;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      rd_en_q    <= in_bounds;
      vld_a_q    <= 1'b1;
      ib_a_q     <= in_bounds;
      sync_a_q   <= {i_hsync, i_vsync, i_de};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_dl_q <= '0;
      ib_dl_q  <= '0;
      for (int unsigned k = 0; k < RAM_LAT; k++) sync_dl_q[k] <= '0;
    end else begin
      vld_dl_q[0]  <= vld_a_q;
      ib_dl_q[0]   <= ib_a_q;
      sync_dl_q[0] <= sync_a_q;
      for (int unsigned k = 1; k < RAM_LAT; k++) begin
        vld_dl_q[k]  <= vld_dl_q[k-1];
        ib_dl_q[k]   <= ib_dl_q[k-1];
        sync_dl_q[k] <= sync_dl_q[k-1];
      end
    end
  end

`ifdef SCANOUT_PALETTE_WR_EN
  typedef logic [23:0] pal_arr_t [PAL_N];

  function automatic pal_arr_t ramp_table();
    pal_arr_t t;
    for (int unsigned i = 0; i < PAL_N; i++) t[i] = ramp_entry(i);
    return t;
  endfunction

  // Power-up contents only; rst deliberately leaves the palette alone.
  logic [23:0] pal_q [PAL_N] = ramp_table();

  always_ff @(posedge clk) begin
    if (pal_we) pal_q[pal_addr] <= pal_data;
  end

  assign pal_rd = pal_q[fb.fb_data];
`else
  logic [23:0] ramp [PAL_N];

  for (genvar g = 0; g < PAL_N; g++) begin : g_ramp
    assign ramp[g] = ramp_entry(g);
  end

  assign pal_rd = ramp[fb.fb_data];
`endif

  // Slots flushed by reset stay black even when BORDER_RGB is not.
  always_comb begin
    rgb_d = '0;
    if (vld_dl_q[RAM_LAT-1]) rgb_d = ib_dl_q[RAM_LAT-1] ? pal_rd : BORDER_RGB;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q    <= '0;
      sync_p_q <= '0;
    end else begin
      rgb_q    <= rgb_d;
      sync_p_q <= sync_dl_q[RAM_LAT-1];
    end
  end

  assign fb.fb_rd_en = rd_en_q;
  assign fb.fb_addr  = addr_q;
  assign o_red       = rgb_q[23:16];
  assign o_green     = rgb_q[15:8];
  assign o_blue      = rgb_q[7:0];
  assign o_hsync     = sync_p_q[2];
  assign o_vsync     = sync_p_q[1];
  assign o_de        = sync_p_q[0];

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: four instances (default, 2x upscale,
// RAM_LAT=2, small 2x-upscaled frame) share one timing stream.
module tb_fb_scanout;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] i_x = '0;
  logic signed [15:0] i_y = '0;
  logic               i_hsync = 1'b0;
  logic               i_vsync = 1'b0;
  logic               i_de = 1'b0;
`ifdef SCANOUT_PALETTE_WR_EN
  logic               pal_we = 1'b0;
  logic [5:0]         pal_addr = '0;
  logic [23:0]        pal_data = '0;
`endif

  logic [5:0]  ram [1024];
  logic [23:0] rgb [4];
  logic [2:0]  syn [4];
  int          n_checks = 0;
  int          n_pass = 0;

  localparam int HR [4] = '{640, 640, 640, 16};
  localparam int VR [4] = '{480, 480, 480, 8};
  localparam int SC [4] = '{0, 1, 0, 1};
  localparam int RL [4] = '{1, 1, 2, 1};

  always #5 clk = ~clk;

  fb_scanout_if #(.ADDR_W(20), .PIX_W(6)) fbi [4] ();

  for (genvar n = 0; n < 4; n++) begin : g_dut
    logic [5:0] dq [2];
    logic [7:0] r, g, b;
    logic       hs, vs, de;

    always @(posedge clk) begin
      dq[0] <= ram[fbi[n].fb_addr[9:0]];
      dq[1] <= dq[0];
    end
    assign fbi[n].fb_data = dq[RL[n]-1];
    assign rgb[n] = {r, g, b};
    assign syn[n] = {hs, vs, de};

    fb_scanout #(
      .H_RES(HR[n]), .V_RES(VR[n]), .SCALE_LOG2(SC[n]), .RAM_LAT(RL[n])
    ) u_dut (
      .clk(clk), .rst(rst), .i_x(i_x), .i_y(i_y),
      .i_hsync(i_hsync), .i_vsync(i_vsync), .i_de(i_de),
      .fb(fbi[n].master),
`ifdef SCANOUT_PALETTE_WR_EN
      .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
`endif
      .o_red(r), .o_green(g), .o_blue(b),
      .o_hsync(hs), .o_vsync(vs), .o_de(de)
    );
  end

  task automatic drive(input int x, input int y, input logic h, input logic v, input logic d);
    i_x = 16'(x);
    i_y = 16'(y);
    i_hsync = h;
    i_vsync = v;
    i_de = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) drive(5, 5, 1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if (rgb[n] !== 24'h0) $display("FAIL reset_rgb[%0d]: got %h want 000000", n, rgb[n]);
      else n_pass++;
      n_checks++;
      if (syn[n] !== 3'b000) $display("FAIL reset_sync[%0d]: got %b want 000", n, syn[n]);
      else n_pass++;
    end
    n_checks++;
    if (fbi[0].fb_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", fbi[0].fb_rd_en);
    else n_pass++;
    n_checks++;
    if (fbi[0].fb_addr !== 20'd0) $display("FAIL reset_addr: got %0d want 0", fbi[0].fb_addr);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_default_mapping();
    int          xs [6] = '{0, 1, 2, 3, -1, -1};
    logic [2:0]  sy [6] = '{3'b001, 3'b101, 3'b011, 3'b001, 3'b000, 3'b000};
    logic [23:0] er [6] = '{24'h0b0b0b, 24'hffffff, 24'hffffff, 24'h858585, 24'h0, 24'h0};
    for (int i = 0; i < 7; i++) begin
      if (i < 6) drive(xs[i], 0, sy[i][2], sy[i][1], sy[i][0]);
      else drive(-1, 0, 1'b0, 1'b0, 1'b0);
      if (i < 4) begin
        n_checks++;
        if (fbi[0].fb_rd_en !== 1'b1 || fbi[0].fb_addr !== 20'(i))
          $display("FAIL map_req[%0d]: got en=%b addr=%0d want en=1 addr=%0d", i, fbi[0].fb_rd_en, fbi[0].fb_addr, i);
        else n_pass++;
      end
      if (i >= 2) begin
        n_checks++;
        if (rgb[0] !== er[i-2]) $display("FAIL map_rgb[%0d]: got %h want %h", i - 2, rgb[0], er[i-2]);
        else n_pass++;
        n_checks++;
        if (syn[0] !== sy[i-2]) $display("FAIL map_sync[%0d]: got %b want %b", i - 2, syn[0], sy[i-2]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_out_of_bounds();
    int          xs [6] = '{639, -1, 640, 0, -10, -10};
    logic [2:0]  sy [6] = '{3'b001, 3'b100, 3'b010, 3'b001, 3'b000, 3'b000};
    logic [23:0] er [6] = '{24'hffffff, 24'h0, 24'h0, 24'h858585, 24'h0, 24'h0};
    logic        en [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int          ea [6] = '{7039, 7039, 7039, 6400, 6400, 6400};
    for (int y = 1; y <= 10; y++) drive(-10, y, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      if (i < 6) drive(xs[i], 10, sy[i][2], sy[i][1], sy[i][0]);
      else drive(-10, 10, 1'b0, 1'b0, 1'b0);
      if (i < 6) begin
        n_checks++;
        if (fbi[0].fb_rd_en !== en[i] || fbi[0].fb_addr !== 20'(ea[i]))
          $display("FAIL oob_req[%0d]: got en=%b addr=%0d want en=%b addr=%0d", i, fbi[0].fb_rd_en, fbi[0].fb_addr, en[i], ea[i]);
        else n_pass++;
      end
      if (i >= 2) begin
        n_checks++;
        if (rgb[0] !== er[i-2]) $display("FAIL oob_rgb[%0d]: got %h want %h", i - 2, rgb[0], er[i-2]);
        else n_pass++;
        n_checks++;
        if (syn[0] !== sy[i-2]) $display("FAIL oob_sync[%0d]: got %b want %b", i - 2, syn[0], sy[i-2]);
        else n_pass++;
      end
    end
    drive(5, 480, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (fbi[0].fb_rd_en !== 1'b0) $display("FAIL oob_y480: got en=%b want 0", fbi[0].fb_rd_en);
    else n_pass++;
    drive(5, -1, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (fbi[0].fb_rd_en !== 1'b0) $display("FAIL oob_yneg: got en=%b want 0", fbi[0].fb_rd_en);
    else n_pass++;
  endtask

  task automatic test_upscale();
    int xs [5] = '{0, 0, 0, 0, 5};
    int ys [5] = '{0, 1, 2, 3, 3};
    int ea [5] = '{0, 0, 320, 320, 322};
    for (int i = 0; i < 5; i++) begin
      drive(xs[i], ys[i], 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (fbi[1].fb_rd_en !== 1'b1 || fbi[1].fb_addr !== 20'(ea[i]))
        $display("FAIL upscale_addr[%0d]: got en=%b addr=%0d want en=1 addr=%0d", i, fbi[1].fb_rd_en, fbi[1].fb_addr, ea[i]);
      else n_pass++;
    end
    n_checks++;
    if (fbi[0].fb_addr !== 20'd1925) $display("FAIL noscale_addr: got %0d want 1925", fbi[0].fb_addr);
    else n_pass++;
  endtask

  task automatic test_full_frame();
    int   cnt [32];
    int   reads = 0, bad_en = 0, bad_addr = 0, bad_cnt = 0;
    logic exp_en;
    for (int a = 0; a < 32; a++) cnt[a] = 0;
    for (int y = 0; y < 8; y++) begin
      for (int x = -2; x < 18; x++) begin
        exp_en = (x >= 0) && (x < 16);
        drive(x, y, 1'b0, 1'b0, exp_en);
        if (fbi[3].fb_rd_en !== exp_en) bad_en++;
        if (fbi[3].fb_rd_en === 1'b1) begin
          reads++;
          if (fbi[3].fb_addr < 20'd32) cnt[fbi[3].fb_addr[4:0]]++;
          if (fbi[3].fb_addr !== 20'((y / 2) * 8 + x / 2)) bad_addr++;
        end
      end
    end
    for (int a = 0; a < 32; a++) if (cnt[a] != 4) bad_cnt++;
    n_checks++;
    if (bad_en != 0) $display("FAIL frame_rd_en: got %0d wrong strobes want 0", bad_en);
    else n_pass++;
    n_checks++;
    if (bad_addr != 0) $display("FAIL frame_addr: got %0d wrong addresses want 0", bad_addr);
    else n_pass++;
    n_checks++;
    if (reads != 128) $display("FAIL frame_reads: got %0d want 128", reads);
    else n_pass++;
    n_checks++;
    if (bad_cnt != 0) $display("FAIL frame_coverage: got %0d addresses not read 4 times want 0", bad_cnt);
    else n_pass++;
  endtask

  task automatic test_read_latency();
    int k;
    for (int y = 0; y <= 50; y++) drive(-1, y, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      if (i < 5) drive(98 + i, 50, (i == 2), 1'b0, 1'b1);
      else drive(-1, 50, 1'b0, 1'b0, 1'b0);
      if (i == 2) begin
        n_checks++;
        if (fbi[2].fb_addr !== 20'd32100) $display("FAIL lat2_addr: got %0d want 32100", fbi[2].fb_addr);
        else n_pass++;
      end
      if (i >= 3) begin
        k = i - 3;
        n_checks++;
        if (rgb[2] !== ((k == 2) ? 24'hffffff : 24'h0))
          $display("FAIL lat2_rgb[%0d]: got %h want %h", k, rgb[2], (k == 2) ? 24'hffffff : 24'h0);
        else n_pass++;
        n_checks++;
        if (syn[2] !== {(k == 2), 1'b0, (k < 5)})
          $display("FAIL lat2_sync[%0d]: got %b want %b", k, syn[2], {(k == 2), 1'b0, (k < 5)});
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [23:0] er [4] = '{24'h0b0b0b, 24'hffffff, 24'hffffff, 24'h858585};
    for (int y = 51; y <= 240; y++) drive(-1, y, 1'b0, 1'b0, 1'b0);
    drive(318, 240, 1'b1, 1'b0, 1'b1);
    drive(319, 240, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    drive(320, 240, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    n_checks++;
    if (fbi[0].fb_rd_en !== 1'b0 || fbi[0].fb_addr !== 20'd0)
      $display("FAIL mid_rst_req: got en=%b addr=%0d want en=0 addr=0", fbi[0].fb_rd_en, fbi[0].fb_addr);
    else n_pass++;
    for (int i = 0; i <= 3; i++) begin
      if (i > 0) drive(320 + i, 240, 1'b1, 1'b0, 1'b1);
      if (i == 1) begin
        n_checks++;
        if (fbi[0].fb_addr !== 20'd321) $display("FAIL mid_rowbase: got %0d want 321", fbi[0].fb_addr);
        else n_pass++;
      end
      if (i < 3) begin
        n_checks++;
        if (rgb[0] !== 24'h0 || syn[0] !== 3'b000)
          $display("FAIL mid_quiet[%0d]: got rgb=%h sync=%b want rgb=000000 sync=000", i, rgb[0], syn[0]);
        else n_pass++;
      end else begin
        n_checks++;
        if (syn[0] !== 3'b101) $display("FAIL mid_resume: got %b want 101", syn[0]);
        else n_pass++;
      end
    end
    for (int i = 0; i < 6; i++) begin
      drive((i < 4) ? i : -1, 0, 1'b0, 1'b0, (i < 4));
      if (i < 4) begin
        n_checks++;
        if (fbi[0].fb_addr !== 20'(i)) $display("FAIL mid_next_addr[%0d]: got %0d want %0d", i, fbi[0].fb_addr, i);
        else n_pass++;
      end
      if (i >= 2) begin
        n_checks++;
        if (rgb[0] !== er[i-2]) $display("FAIL mid_next_rgb[%0d]: got %h want %h", i - 2, rgb[0], er[i-2]);
        else n_pass++;
      end
    end
  endtask

`ifdef SCANOUT_PALETTE_WR_EN
  task automatic test_palette_write();
    logic [23:0] exp;
    for (int i = 0; i < 10; i++) begin
      pal_we = (i == 4);
      pal_addr = 6'd5;
      pal_data = 24'hff0000;
      if (i < 8) drive(4 + i, 0, 1'b0, 1'b0, 1'b1);
      else drive(-1, 0, 1'b0, 1'b0, 1'b0);
      if (i >= 2) begin
        exp = (i - 2 >= 8) ? 24'h0 : ((i <= 4) ? 24'h373737 : 24'hff0000);
        n_checks++;
        if (rgb[0] !== exp) $display("FAIL palwr_rgb[%0d]: got %h want %h", i - 2, rgb[0], exp);
        else n_pass++;
      end
    end
    pal_we = 1'b0;
    rst = 1'b1;
    drive(-1, 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive((i < 4) ? 4 + i : -1, 0, 1'b0, 1'b0, (i < 4));
      if (i >= 2) begin
        n_checks++;
        if (rgb[0] !== 24'hff0000) $display("FAIL palwr_after_rst[%0d]: got %h want ff0000", i - 2, rgb[0]);
        else n_pass++;
      end
    end
  endtask
`endif

  initial begin
    for (int a = 0; a < 1024; a++) ram[a] = '0;
    ram[0] = 6'd1;
    ram[1] = 6'd23;
    ram[2] = 6'd40;
    ram[3] = 6'd12;
    ram[256] = 6'd12;
    ram[356] = 6'd23;
    ram[895] = 6'd23;
    for (int a = 4; a < 12; a++) ram[a] = 6'd5;

    test_reset();
    test_default_mapping();
    test_out_of_bounds();
    test_upscale();
    test_full_frame();
    test_read_latency();
    test_reset_midframe();
`ifdef SCANOUT_PALETTE_WR_EN
    test_palette_write();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
